mem_request_master: RTL

//  Initiator side of the memory_controller read/write interface. Accepts host

---
 rtl/mem_request_master.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_request_master.sv
// mem_request_master: buffers host commands in a small FIFO and replays them
// as one-cycle read/write strobes to a memory controller, returning read data.
module mem_request_master #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_val,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_value
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]     r_q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_q_write;
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;

    logic [PTR_W:0]   w_count;
    logic [PTR_W-1:0] w_widx;
    logic [PTR_W-1:0] w_ridx;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_val;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;
    logic [CNT_W-1:0]  r_rd_count;
    logic [CNT_W-1:0]  r_wr_count;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign w_widx  = r_wptr[PTR_W-1:0];
    assign w_ridx  = r_rptr[PTR_W-1:0];
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == FULL_CNT);
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[w_widx]  <= cmd_addr;
            r_q_data[w_widx]  <= cmd_wdata;
            r_q_write[w_widx] <= cmd_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (!w_empty) w_next = S_ISSUE;
            S_ISSUE:   w_next = r_mem_write ? S_IDLE : S_CAPTURE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_address <= '0;
            r_mem_val     <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_addr    <= '0;
            r_rsp_data    <= '0;
            r_rd_count    <= '0;
            r_wr_count    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
                r_mem_address <= r_q_addr[w_ridx];
                r_mem_val     <= r_q_write[w_ridx] ? r_q_data[w_ridx] : '0;
                r_mem_write   <= r_q_write[w_ridx];
                r_mem_read    <= !r_q_write[w_ridx];
            end else begin
                r_mem_write <= 1'b0;
                r_mem_read  <= 1'b0;
            end
            if (r_state == S_ISSUE && r_mem_write) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            // Controller value is registered off the read strobe; valid now.
            if (r_state == S_CAPTURE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= r_mem_address;
                r_rsp_data  <= mem_value;
                r_rd_count  <= r_rd_count + 1'b1;
            end
        end
    end

    assign cmd_ready   = !w_full;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign mem_address = r_mem_address;
    assign mem_val     = r_mem_val;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_data    = r_rsp_data;
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;

endmodule
